bmc_soft_pipe: RTL

- Parametrised successor to the fixed 2-bit hard-decision branch metric unit.
- Computes branch metrics against all 2^N_BITS expected code-symbol patterns for one trellis step, with soft-decision inputs.
- Two-stage registered pipeline with valid/ready handshake.
- Sits between the demodulator/depuncturer front end and the add-compare-select array of the Viterbi decoder.

---
 rtl/bmc_soft_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch metric unit: metrics against all 2^N_BITS code patterns, two-stage valid/ready pipe.
// Optional PUNCTURE_EN adds a puncture phase counter, symbol erasure and the punc_out port.
module bmc_soft_pipe #(
   parameter int N_BITS      = 2,
   parameter int SOFT_W      = 3,
   parameter int M_W         = SOFT_W + $clog2(N_BITS + 1),
   parameter int PUNC_PERIOD = 2,
   parameter logic [N_BITS*PUNC_PERIOD-1:0] PUNC_MASK = '1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_sof,
   input  logic [N_BITS*SOFT_W-1:0]       rx_soft,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [(2**N_BITS)*M_W-1:0]     bm_out,
   output logic                           out_sof
`ifdef PUNCTURE_EN
   ,
   output logic [N_BITS-1:0]              punc_out
`endif
);

   localparam int N_PAT = 2**N_BITS;
   localparam logic [SOFT_W-1:0] S_MAX = '1;

   if (N_BITS < 1 || N_BITS > 4) begin : g_bad_n_bits
      $error("bmc_soft_pipe: N_BITS must be in 1..4");
   end
   if (M_W != SOFT_W + $clog2(N_BITS + 1)) begin : g_bad_m_w
      $error("bmc_soft_pipe: M_W is derived and must not be overridden");
   end
   if ($bits(PUNC_MASK) != N_BITS * PUNC_PERIOD) begin : g_bad_mask
      $error("bmc_soft_pipe: PUNC_MASK width must be N_BITS*PUNC_PERIOD");
   end

   function automatic logic [SOFT_W-1:0] dist_to_one(input logic [SOFT_W-1:0] s);
      return S_MAX - s;
   endfunction

   function automatic logic [M_W-1:0] zext_dist(input logic [SOFT_W-1:0] d);
      return M_W'(d);
   endfunction

   logic vld_p1, vld_p2;
   logic en1, en2, xfer;

   assign en2      = ~vld_p2 | out_ready;
   assign en1      = ~vld_p1 | en2;
   assign in_ready = en1;
   assign xfer     = in_valid & en1;

   logic [N_BITS-1:0] keep_p0;

`ifdef PUNCTURE_EN
   localparam int PH_W = (PUNC_PERIOD > 1) ? $clog2(PUNC_PERIOD) : 1;

   logic [PH_W-1:0] ph_q, ph_use_p0, ph_nxt_p0;

   // in_sof forces phase 0 so the puncture pattern is realigned to the frame start
   always_comb begin
      ph_use_p0 = in_sof ? '0 : ph_q;
      ph_nxt_p0 = (int'(ph_use_p0) == PUNC_PERIOD - 1) ? '0 : ph_use_p0 + PH_W'(1);
      keep_p0   = '1;
      for (int ph = 0; ph < PUNC_PERIOD; ph++) begin
         if (int'(ph_use_p0) == ph) keep_p0 = PUNC_MASK[ph*N_BITS +: N_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ph_q <= '0;
      else if (xfer) ph_q <= ph_nxt_p0;
   end
`else
   assign keep_p0 = '1;
`endif

   // ---- stage 1: per-symbol distances ----
   logic [SOFT_W-1:0] d0_p1 [N_BITS];
   logic [SOFT_W-1:0] d1_p1 [N_BITS];
   logic              sof_p1;
   logic [N_BITS-1:0] punc_p1;

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else if (en1) vld_p1 <= xfer;
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         sof_p1  <= in_sof;
         punc_p1 <= ~keep_p0;
         for (int k = 0; k < N_BITS; k++) begin
            d0_p1[k] <= keep_p0[k] ? rx_soft[k*SOFT_W +: SOFT_W] : '0;
            d1_p1[k] <= keep_p0[k] ? dist_to_one(rx_soft[k*SOFT_W +: SOFT_W]) : '0;
         end
      end
   end

   logic [M_W-1:0] sum_p1 [N_PAT];

   always_comb begin
      for (int p = 0; p < N_PAT; p++) begin
         sum_p1[p] = '0;
         for (int k = 0; k < N_BITS; k++) begin
            if (((p >> k) & 1) != 0) sum_p1[p] = sum_p1[p] + zext_dist(d1_p1[k]);
            else                     sum_p1[p] = sum_p1[p] + zext_dist(d0_p1[k]);
         end
      end
   end

   // ---- stage 2: pattern metrics, driven straight to the outputs ----
   logic [N_PAT*M_W-1:0] bm_p2;
   logic                 sof_p2;
   logic [N_BITS-1:0]    punc_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         bm_p2   <= '0;
         sof_p2  <= 1'b0;
         punc_p2 <= '0;
      end else if (en2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sof_p2  <= sof_p1;
            punc_p2 <= punc_p1;
            for (int p = 0; p < N_PAT; p++) bm_p2[p*M_W +: M_W] <= sum_p1[p];
         end
      end
   end

   assign out_valid = vld_p2;
   assign bm_out    = bm_p2;
   assign out_sof   = sof_p2;

`ifdef PUNCTURE_EN
   assign punc_out = punc_p2;
`else
   logic unused_punc;
   assign unused_punc = ^punc_p2;
`endif

endmodule
